flappy_game_ctrl: RTL and testbench
===================================

FLAPPY_GAME_CTRL -- requirements
Module: flappy_game_ctrl

Interface
REQ-001 The block SHALL have parameter GRAV_DIV, default 8, meaning clocks per gravity tick (legal range 2..255).
REQ-002 The block SHALL have parameter PIPE_DIV, default 16, meaning clocks per pipe-scroll step (legal range 2..255).
REQ-003 Port clk  input  1  is the single clock; all state SHALL update on its rising edge.
REQ-004 Port reset  input  1  is a synchronous, active-low reset (0 = reset), sampled on rising clk.
REQ-005 Port press  input  1  is the player key, level, already synchronised to clk.
REQ-006 Port position  input  8  is the bird row vector, one-hot, where bit 7 is the top row and all-zero means the bird is lost.
REQ-007 Port pipe_col  input  8  is the pipe occupancy of the bird's column, where 1 means the pipe is lit.
REQ-008 Port cycle  output  1  is the gravity tick pulse to the bird movement block.
REQ-009 Port pipe_shift  output  1  is the one-clock pulse that advances the pipe field.
REQ-010 Port bird_press  output  1  is the gated press forwarded to the bird movement block.
REQ-011 Port bird_reset  output  1  is the active-high reset to the bird movement block (re-centres the bird).
REQ-012 Port game_state  output  2  encodes the state: 00 = IDLE, 01 = PLAY, 10 = DEAD.
REQ-013 Port score  output  8  is the score as two BCD digits: [7:4] tens, [3:0] units.

Function
REQ-014 The FSM SHALL have exactly the states IDLE, PLAY and DEAD; encoding 11 SHALL be unreachable and SHALL recover to IDLE on the next clock.
REQ-015 Press edge: rise SHALL be computed as press & ~press_q, where press_q is press registered one clock earlier.
REQ-016 In IDLE, a rise SHALL cause the transition to PLAY on the next clock, clear score to 00, and clear both divider counters.
REQ-017 In PLAY:
- the gravity counter SHALL count 0..GRAV_DIV-1 and wrap;
- cycle SHALL be 1 for exactly the one clock in which the counter equals GRAV_DIV-1.
REQ-018 In PLAY:
- the pipe counter SHALL count 0..PIPE_DIV-1 independently of the gravity counter;
- pipe_shift SHALL be 1 for exactly the one clock in which it equals PIPE_DIV-1.
REQ-019 Coincident cycle and pipe_shift pulses SHALL both be issued in the same clock.
REQ-020 bird_press SHALL equal press while in PLAY and SHALL be 0 in IDLE and DEAD.
REQ-021 bird_reset SHALL be 1 in IDLE and 0 in PLAY and DEAD, so the bird is frozen where it died.
REQ-022 Collision SHALL be (position & pipe_col) != 0, or position == 0, evaluated combinationally in PLAY; on collision the state SHALL become DEAD at the next clock.
REQ-023 Score event:
- in PLAY, a pipe_shift clock with pipe_col != 0 and no collision in that clock SHALL increment score by 1 (BCD, units 9 -> 0 with tens carry);
- score SHALL saturate at 99.
REQ-024 Collision SHALL take priority over a score event in the same clock: no increment, and the transition to DEAD.
REQ-025 In DEAD:
- cycle, pipe_shift and bird_press SHALL be 0;
- the counters SHALL hold;
- score SHALL hold.
REQ-026 In DEAD, a rise SHALL transition to IDLE on the next clock. A press still held from PLAY SHALL NOT count as a rise.
REQ-027 Outputs cycle, pipe_shift, game_state and score SHALL be registered. bird_press and bird_reset SHALL be decoded from the registered state.

Reset
REQ-028 While reset == 0 at a rising clk, the following SHALL hold at the next clock: state = IDLE, both counters = 0, press_q = 0, score = 00, cycle = 0, pipe_shift = 0.
REQ-029 During and after reset, bird_reset SHALL be 1 and bird_press SHALL be 0.
REQ-030 Reset asserted mid-PLAY or mid-DEAD SHALL abort the game with the same values as REQ-028 and REQ-029, with no pulse emitted in the reset clock.
REQ-031 If press is held high through reset release, it SHALL register as a rise on the first clock after release.

Verification
REQ-032 Reset, then press 0->1 -> game_state 00 then 01 one clock later; score = 00; bird_reset = 0.
REQ-033 PLAY with defaults for 48 clocks, no collision:
- cycle pulses exactly 6 times, every 8 clocks;
- pipe_shift pulses exactly 3 times, every 16 clocks;
- clocks 15/31/47 show both pulses together.
REQ-034 PLAY, position = 8'h10, pipe_col = 8'h0F on each pipe_shift: score steps 00 -> 01 -> ... -> 09 -> 10. A forced score of 99 stays at 99 on the next event.
REQ-035 PLAY, position = 8'h10, pipe_col = 8'h10 in the pipe_shift clock:
- game_state = 10 the next clock;
- score unchanged;
- cycle, pipe_shift and bird_press all stay 0 thereafter.
REQ-036 DEAD with press held high -> remains DEAD. Release then press again -> IDLE (bird_reset = 1), and a further rise -> PLAY with score = 00.
REQ-037 Reset pulled to 0 in PLAY at counter value 5 -> next clock game_state = 00, score = 00, no cycle or pipe_shift pulse.

Source files
------------

// File: rtl/flappy_game_ctrl.sv
// flappy_game_ctrl: game sequencer for a flappy-bird style game. It paces gravity
// and pipe scrolling, gates the player key, detects collisions and keeps a BCD score.
`default_nettype none

module flappy_game_ctrl #(
  parameter int GRAV_DIV = 8,
  parameter int PIPE_DIV = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       press,
  input  logic [7:0] position,
  input  logic [7:0] pipe_col,
  output logic       cycle,
  output logic       pipe_shift,
  output logic       bird_press,
  output logic       bird_reset,
  output logic [1:0] game_state,
  output logic [7:0] score
);

  localparam logic [1:0] S_IDLE = 2'b00;
  localparam logic [1:0] S_PLAY = 2'b01;
  localparam logic [1:0] S_DEAD = 2'b10;

  localparam logic [7:0] c_GMAX = 8'(GRAV_DIV - 1);
  localparam logic [7:0] c_PMAX = 8'(PIPE_DIV - 1);

  logic [1:0] r_state;
  logic       r_press_q;
  logic [7:0] r_gcnt;
  logic [7:0] r_pcnt;
  logic       r_cycle;
  logic       r_pipe_shift;
  logic [7:0] r_score;

  logic [1:0] w_state_nxt;
  logic [7:0] w_gcnt_nxt;
  logic [7:0] w_pcnt_nxt;
  logic [7:0] w_score_inc;
  logic       w_rise;
  logic       w_collide;
  logic       w_score_evt;

  assign w_rise      = press & ~r_press_q;
  assign w_collide   = (r_state == S_PLAY) &&
                       (((position & pipe_col) != 8'h00) || (position == 8'h00));
  assign w_score_evt = (r_state == S_PLAY) && r_pipe_shift &&
                       (pipe_col != 8'h00) && !w_collide;

  // BCD increment; the caller guards saturation at 99.
  assign w_score_inc = (r_score[3:0] == 4'd9) ? {r_score[7:4] + 4'd1, 4'd0}
                                              : {r_score[7:4], r_score[3:0] + 4'd1};

  always_comb begin
    w_state_nxt = r_state;
    w_gcnt_nxt  = r_gcnt;
    w_pcnt_nxt  = r_pcnt;
    case (r_state)
      S_IDLE: begin
        w_gcnt_nxt = 8'd0;
        w_pcnt_nxt = 8'd0;
        if (w_rise) w_state_nxt = S_PLAY;
      end
      S_PLAY: begin
        w_gcnt_nxt = (r_gcnt >= c_GMAX) ? 8'd0 : r_gcnt + 8'd1;
        w_pcnt_nxt = (r_pcnt >= c_PMAX) ? 8'd0 : r_pcnt + 8'd1;
        if (w_collide) w_state_nxt = S_DEAD;
      end
      S_DEAD: begin
        if (w_rise) w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_gcnt_nxt  = 8'd0;
        w_pcnt_nxt  = 8'd0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state      <= S_IDLE;
      r_press_q    <= 1'b0;
      r_gcnt       <= 8'd0;
      r_pcnt       <= 8'd0;
      r_cycle      <= 1'b0;
      r_pipe_shift <= 1'b0;
      r_score      <= 8'h00;
    end else begin
      r_state   <= w_state_nxt;
      r_press_q <= press;
      r_gcnt    <= w_gcnt_nxt;
      r_pcnt    <= w_pcnt_nxt;
      // Pulses are registered ahead so they line up with the counter's terminal value.
      r_cycle      <= (w_state_nxt == S_PLAY) && (w_gcnt_nxt == c_GMAX);
      r_pipe_shift <= (w_state_nxt == S_PLAY) && (w_pcnt_nxt == c_PMAX);
      if ((r_state == S_IDLE) && w_rise)
        r_score <= 8'h00;
      else if (w_score_evt && (r_score != 8'h99))
        r_score <= w_score_inc;
    end
  end

  assign cycle      = r_cycle;
  assign pipe_shift = r_pipe_shift;
  assign game_state = r_state;
  assign score      = r_score;
  assign bird_press = (r_state == S_PLAY) & press;
  assign bird_reset = (r_state != S_PLAY) && (r_state != S_DEAD);

endmodule

`default_nettype wire

// File: tb/tb_flappy_game_ctrl.sv
// tb_flappy_game_ctrl: vector table, directed corner cases and random stimulus
// checked against a rule-level model of the game controller.
`default_nettype none

module tb_flappy_game_ctrl;

  localparam int G = 8;
  localparam int P = 16;

  logic       clk = 1'b0;
  logic       reset;
  logic       press;
  logic [7:0] position;
  logic [7:0] pipe_col;
  logic       cycle;
  logic       pipe_shift;
  logic       bird_press;
  logic       bird_reset;
  logic [1:0] game_state;
  logic [7:0] score;

  flappy_game_ctrl #(.GRAV_DIV(G), .PIPE_DIV(P)) dut (
    .clk(clk), .reset(reset), .press(press), .position(position),
    .pipe_col(pipe_col), .cycle(cycle), .pipe_shift(pipe_shift),
    .bird_press(bird_press), .bird_reset(bird_reset),
    .game_state(game_state), .score(score)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Model: game phase (0 idle, 1 play, 2 dead), clocks spent in play, last press, score.
  int   m_st;
  int   m_k;
  bit   m_pq;
  int   m_score;
  logic s_cycle, s_ps, s_bp;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] bcd(input int v);
    return {4'(v / 10), 4'(v % 10)};
  endfunction

  task automatic model_reset();
    m_st = 0; m_k = 0; m_pq = 0; m_score = 0;
  endtask

  // Drive one clock of inputs, check outputs mid-cycle against the model, advance.
  task automatic step(input logic r, input logic p, input logic [7:0] pos, input logic [7:0] pc);
    bit e_cyc, e_ps, coll, rise;
    reset = r; press = p; position = pos; pipe_col = pc;
    #4;
    e_cyc = (m_st == 1) && ((m_k % G) == G - 1);
    e_ps  = (m_st == 1) && ((m_k % P) == P - 1);
    check("cycle",      32'(cycle),      32'(e_cyc));
    check("pipe_shift", 32'(pipe_shift), 32'(e_ps));
    check("bird_press", 32'(bird_press), 32'((m_st == 1) && p));
    check("bird_reset", 32'(bird_reset), 32'(m_st == 0));
    check("game_state", 32'(game_state), 32'(m_st));
    check("score",      32'(score),      32'(bcd(m_score)));
    s_cycle = cycle; s_ps = pipe_shift; s_bp = bird_press;
    if (!r) begin
      model_reset();
    end else begin
      coll = (m_st == 1) && (((pos & pc) != 0) || (pos == 0));
      rise = p && !m_pq;
      case (m_st)
        0: if (rise) begin m_st = 1; m_k = 0; m_score = 0; end
        1: begin
          if (e_ps && (pc != 0) && !coll && (m_score < 99)) m_score++;
          m_k++;
          if (coll) m_st = 2;
        end
        default: if (rise) m_st = 0;
      endcase
      m_pq = p;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic go_play();
    step(1'b0, 1'b0, 8'h10, 8'h00);
    step(1'b1, 1'b1, 8'h10, 8'h00);
  endtask

  typedef struct {
    logic       rst;
    logic       prs;
    logic [7:0] pos;
    logic [7:0] pc;
    logic [1:0] st;
    logic [7:0] sc;
    logic       br;
  } vec_t;

  vec_t tbl[13];

  initial begin
    int nc, np;
    logic p;
    logic [7:0] pos, pc;

    tbl[0]  = '{1'b0, 1'b0, 8'h10, 8'h00, 2'b00, 8'h00, 1'b1};
    tbl[1]  = '{1'b1, 1'b0, 8'h10, 8'h00, 2'b00, 8'h00, 1'b1};
    tbl[2]  = '{1'b1, 1'b1, 8'h10, 8'h00, 2'b01, 8'h00, 1'b0};
    tbl[3]  = '{1'b1, 1'b1, 8'h10, 8'h00, 2'b01, 8'h00, 1'b0};
    tbl[4]  = '{1'b1, 1'b0, 8'h10, 8'h10, 2'b10, 8'h00, 1'b0};
    tbl[5]  = '{1'b1, 1'b1, 8'h10, 8'h00, 2'b00, 8'h00, 1'b1};
    tbl[6]  = '{1'b1, 1'b1, 8'h10, 8'h00, 2'b00, 8'h00, 1'b1};
    tbl[7]  = '{1'b1, 1'b0, 8'h10, 8'h00, 2'b00, 8'h00, 1'b1};
    tbl[8]  = '{1'b1, 1'b1, 8'h10, 8'h00, 2'b01, 8'h00, 1'b0};
    tbl[9]  = '{1'b1, 1'b0, 8'h00, 8'h00, 2'b10, 8'h00, 1'b0};
    tbl[10] = '{1'b0, 1'b1, 8'h10, 8'h00, 2'b00, 8'h00, 1'b1};
    tbl[11] = '{1'b1, 1'b1, 8'h10, 8'h00, 2'b01, 8'h00, 1'b0};
    tbl[12] = '{1'b1, 1'b1, 8'h10, 8'h0F, 2'b01, 8'h00, 1'b0};

    reset = 1'b0; press = 1'b0; position = 8'h10; pipe_col = 8'h00;
    repeat (2) @(posedge clk);
    #1;
    model_reset();

    for (int i = 0; i < 13; i++) begin
      step(tbl[i].rst, tbl[i].prs, tbl[i].pos, tbl[i].pc);
      check("tbl_state", 32'(game_state), 32'(tbl[i].st));
      check("tbl_score", 32'(score),      32'(tbl[i].sc));
      check("tbl_bird_reset", 32'(bird_reset), 32'(tbl[i].br));
    end

    // Pulse cadence over 48 play clocks.
    go_play();
    nc = 0; np = 0;
    for (int k = 0; k < 48; k++) begin
      step(1'b1, 1'b0, 8'h10, 8'h0F);
      if (s_cycle) nc++;
      if (s_ps) np++;
      if (k == 15 || k == 31 || k == 47)
        check("both_pulses", {30'd0, s_cycle, s_ps}, 32'h3);
    end
    check("cycle_count", nc, 6);
    check("pipe_count",  np, 3);

    // Score stepping through the tens carry and saturation at 99.
    go_play();
    for (int e = 1; e <= 100; e++) begin
      repeat (P) step(1'b1, 1'b0, 8'h10, 8'h0F);
      check("score_step", 32'(score), 32'(bcd(e > 99 ? 99 : e)));
    end
    check("score_sat", 32'(score), 32'h99);

    // Collision in the pipe_shift clock, then a held press in DEAD.
    go_play();
    repeat (P - 1) step(1'b1, 1'b0, 8'h10, 8'h00);
    step(1'b1, 1'b1, 8'h10, 8'h10);
    check("dead_state", 32'(game_state), 32'h2);
    check("dead_score", 32'(score), 32'h00);
    for (int k = 0; k < 40; k++) begin
      step(1'b1, 1'b1, 8'h10, 8'h10);
      check("dead_quiet", {29'd0, s_cycle, s_ps, s_bp}, 32'h0);
    end
    check("dead_held", 32'(game_state), 32'h2);
    step(1'b1, 1'b0, 8'h10, 8'h00);
    step(1'b1, 1'b1, 8'h10, 8'h00);
    check("dead_to_idle", 32'(game_state), 32'h0);
    check("idle_bird_reset", 32'(bird_reset), 32'h1);
    step(1'b1, 1'b0, 8'h10, 8'h00);
    step(1'b1, 1'b1, 8'h10, 8'h00);
    check("replay_state", 32'(game_state), 32'h1);
    check("replay_score", 32'(score), 32'h00);

    // Reset mid-play at counter value 5.
    go_play();
    repeat (5) step(1'b1, 1'b0, 8'h10, 8'h00);
    step(1'b0, 1'b0, 8'h10, 8'h00);
    check("rst_state", 32'(game_state), 32'h0);
    check("rst_score", 32'(score), 32'h00);
    check("rst_pulses", {30'd0, cycle, pipe_shift}, 32'h0);

    // Random play against the model.
    p = 1'b0;
    for (int n = 0; n < 4000; n++) begin
      if ($urandom_range(0, 3) == 0) p = ~p;
      pos = ($urandom_range(0, 15) == 0) ? 8'h00 : 8'(1 << $urandom_range(0, 7));
      pc  = ($urandom_range(0, 19) == 0) ? 8'($urandom) : 8'h00;
      step(($urandom_range(0, 63) != 0), p, pos, pc);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
